// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Owns the single write port of the processor register file. After reset,
//   or when clr_req is pulsed in RUN, it sweeps every register to INIT_VALUE
//   one index per cycle. In RUN it shares the port between two requesters
//   (0 = ALU writeback, 1 = load-return/debug) using a valid/ready handshake
//   with round-robin priority on ties.
//
// Ports
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   clr_req                pulse in RUN to restart the clear sweep
//   req0_valid/ind/data    requester 0 write request
//   req0_ready             requester 0 accepted this cycle (valid & ready)
//   req1_valid/ind/data    requester 1 write request
//   req1_ready             requester 1 accepted this cycle (valid & ready)
//   rf_wrtEn/wrtInd/dIn    registered drive for the register file write port
//   init_done              high in RUN, low while sweeping
//   busy                   high while sweeping, or in RUN with a pending valid
module regfile_write_arbiter #(
    parameter int unsigned      DBITS      = 32,
    parameter int unsigned      ABITS      = 5,
    parameter int unsigned      WORDS      = 1 << ABITS,
    parameter logic [DBITS-1:0] INIT_VALUE = '0,
    parameter bit               ZERO_REG   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_req,
    input  logic             req0_valid,
    input  logic [ABITS-1:0] req0_ind,
    input  logic [DBITS-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [ABITS-1:0] req1_ind,
    input  logic [DBITS-1:0] req1_data,
    output logic             req1_ready,
    output logic             rf_wrtEn,
    output logic [ABITS-1:0] rf_wrtInd,
    output logic [DBITS-1:0] rf_dIn,
    output logic             init_done,
    output logic             busy
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // One extra bit so a full 1<<ABITS sweep ends without wrapping to 0.
    localparam logic [ABITS:0] LAST_IDX = (ABITS + 1)'(WORDS - 1);

    logic [0:0]       state;
    logic [ABITS:0]   idx;
    logic             last_grant;   // 0: requester 0 won last, 1: requester 1

    logic             take0;
    logic             take1;
    logic [ABITS-1:0] sel_ind;
    logic [DBITS-1:0] sel_data;
    logic             drop;

    // Round-robin: on a tie, the requester that did not win last time wins.
    // clr_req in RUN blocks all grants so no transfer races the restart.
    always_comb begin
        take0    = 1'b0;
        take1    = 1'b0;
        sel_ind  = req0_ind;
        sel_data = req0_data;
        if (state == ST_RUN && !clr_req) begin
            take0 = req0_valid && (!req1_valid || last_grant);
            take1 = req1_valid && (!req0_valid || !last_grant);
        end
        if (take1) begin
            sel_ind  = req1_ind;
            sel_data = req1_data;
        end
    end

    // Index 0 is hard-wired zero when ZERO_REG is set: accept, but never write.
    assign drop       = ZERO_REG && (sel_ind == '0);

    assign req0_ready = take0;
    assign req1_ready = take1;
    assign init_done  = (state == ST_RUN);
    assign busy       = !init_done || req0_valid || req1_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_INIT;
            idx        <= '0;
            last_grant <= 1'b1;
            rf_wrtEn   <= 1'b0;
            rf_wrtInd  <= '0;
            rf_dIn     <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    rf_wrtEn  <= 1'b1;
                    rf_wrtInd <= idx[ABITS-1:0];
                    rf_dIn    <= INIT_VALUE;
                    idx       <= idx + (ABITS + 1)'(1);
                    if (idx == LAST_IDX) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    if (clr_req) begin
                        state    <= ST_INIT;
                        idx      <= '0;
                        rf_wrtEn <= 1'b0;
                    end else if (take0 || take1) begin
                        rf_wrtEn   <= !drop;
                        rf_wrtInd  <= sel_ind;
                        rf_dIn     <= sel_data;
                        last_grant <= take1;
                    end else begin
                        rf_wrtEn <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter
//   Directed bench for regfile_write_arbiter (ABITS=3, INIT_VALUE=0xA5,
//   ZERO_REG=1). Each driven cycle pushes the expected registered write-port
//   contents to a queue; they are popped and compared after the next edge.
module tb_regfile_write_arbiter;

    localparam int unsigned DBITS = 32;
    localparam int unsigned ABITS = 3;
    localparam int unsigned WORDS = 8;
    localparam logic [31:0] INITV = 32'h0000_00A5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr_req = 1'b0;
    logic             req0_valid = 1'b0;
    logic [ABITS-1:0] req0_ind = '0;
    logic [DBITS-1:0] req0_data = '0;
    logic             req0_ready;
    logic             req1_valid = 1'b0;
    logic [ABITS-1:0] req1_ind = '0;
    logic [DBITS-1:0] req1_data = '0;
    logic             req1_ready;
    logic             rf_wrtEn;
    logic [ABITS-1:0] rf_wrtInd;
    logic [DBITS-1:0] rf_dIn;
    logic             init_done;
    logic             busy;

    regfile_write_arbiter #(
        .DBITS(DBITS),
        .ABITS(ABITS),
        .WORDS(WORDS),
        .INIT_VALUE(INITV),
        .ZERO_REG(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req),
        .req0_valid(req0_valid), .req0_ind(req0_ind), .req0_data(req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_ind(req1_ind), .req1_data(req1_data),
        .req1_ready(req1_ready),
        .rf_wrtEn(rf_wrtEn), .rf_wrtInd(rf_wrtInd), .rf_dIn(rf_dIn),
        .init_done(init_done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             en;
        logic [ABITS-1:0] ind;
        logic [DBITS-1:0] data;
    } wr_t;

    wr_t              sb[$];
    int               total = 0;
    int               bad = 0;
    logic [ABITS-1:0] m_ind = '0;
    logic [DBITS-1:0] m_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // After the edge: pop the expected write-port contents and compare.
    task automatic pop_check(input string tag);
        wr_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s: scoreboard empty got 1 expected 0", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".en"}, {31'd0, rf_wrtEn}, {31'd0, e.en});
            chk({tag, ".ind"}, {29'd0, rf_wrtInd}, {29'd0, e.ind});
            chk({tag, ".data"}, rf_dIn, e.data);
        end
    endtask

    // One RUN cycle, entered and left at a negedge. e0/e1 are the expected readies.
    task automatic cyc(input string tag,
                       input logic v0, input logic [ABITS-1:0] i0, input logic [DBITS-1:0] d0,
                       input logic v1, input logic [ABITS-1:0] i1, input logic [DBITS-1:0] d1,
                       input logic clr, input logic e0, input logic e1);
        wr_t w;
        req0_valid = v0; req0_ind = i0; req0_data = d0;
        req1_valid = v1; req1_ind = i1; req1_data = d1;
        clr_req = clr;
        #1;
        chk({tag, ".r0"}, {31'd0, req0_ready}, {31'd0, e0});
        chk({tag, ".r1"}, {31'd0, req1_ready}, {31'd0, e1});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, v0 | v1});
        w.en = 1'b0;
        if (e0) begin
            m_ind = i0; m_data = d0; w.en = (i0 != '0);
        end else if (e1) begin
            m_ind = i1; m_data = d1; w.en = (i1 != '0);
        end
        w.ind = m_ind;
        w.data = m_data;
        sb.push_back(w);
        @(posedge clk);
        #1;
        pop_check(tag);
        chk({tag, ".done"}, {31'd0, init_done}, {31'd0, !clr});
        clr_req = 1'b0;
        @(negedge clk);
    endtask

    // n cycles of the INIT sweep starting from index 0, with both requesters
    // pushing so that ready staying low is actually exercised.
    task automatic init_sweep(input string tag, input int unsigned n);
        wr_t w;
        for (int unsigned k = 0; k < n; k++) begin
            req0_valid = 1'b1; req0_ind = 3'd5; req0_data = 32'h77;
            req1_valid = 1'b1; req1_ind = 3'd6; req1_data = 32'h66;
            #1;
            chk({tag, ".r0"}, {31'd0, req0_ready}, 32'd0);
            chk({tag, ".r1"}, {31'd0, req1_ready}, 32'd0);
            chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
            chk({tag, ".done0"}, {31'd0, init_done}, 32'd0);
            w.en = 1'b1;
            w.ind = ABITS'(k);
            w.data = INITV;
            m_ind = w.ind;
            m_data = w.data;
            sb.push_back(w);
            @(posedge clk);
            #1;
            pop_check(tag);
            @(negedge clk);
        end
        if (n == WORDS) begin
            chk({tag, ".done1"}, {31'd0, init_done}, 32'd1);
        end
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, ".en"}, {31'd0, rf_wrtEn}, 32'd0);
        chk({tag, ".ind"}, {29'd0, rf_wrtInd}, 32'd0);
        chk({tag, ".data"}, rf_dIn, 32'd0);
        chk({tag, ".done"}, {31'd0, init_done}, 32'd0);
        chk({tag, ".r0"}, {31'd0, req0_ready}, 32'd0);
        chk({tag, ".r1"}, {31'd0, req1_ready}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state, then the first sweep.
        @(negedge clk);
        reset_vals("reset");
        rst_n = 1'b1;
        m_ind = '0;
        m_data = '0;
        init_sweep("init", WORDS);

        // Idle: neither valid, no write, outputs hold.
        cyc("idle", 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0);

        // Ties alternate, first tie after reset goes to requester 0.
        cyc("tie0", 1'b1, 3'd1, 32'h1111, 1'b1, 3'd2, 32'h2222, 1'b0, 1'b1, 1'b0);
        cyc("tie1", 1'b1, 3'd1, 32'h1112, 1'b1, 3'd2, 32'h2223, 1'b0, 1'b0, 1'b1);
        cyc("tie2", 1'b1, 3'd4, 32'h1113, 1'b1, 3'd5, 32'h2224, 1'b0, 1'b1, 1'b0);
        cyc("tie3", 1'b1, 3'd4, 32'h1114, 1'b1, 3'd7, 32'h2225, 1'b0, 1'b0, 1'b1);

        // Single requester 0 write, then an idle cycle holding ind/data.
        cyc("req0", 1'b1, 3'd3, 32'h1234, 1'b0, 3'd6, 32'h9999, 1'b0, 1'b1, 1'b0);
        cyc("hold", 1'b0, 3'd3, 32'h1234, 1'b0, 3'd6, 32'h9999, 1'b0, 1'b0, 1'b0);

        // Write to index 0 is accepted but dropped; the following tie goes to req0.
        cyc("zero", 1'b0, 3'd2, 32'h5555, 1'b1, 3'd0, 32'hFFFF, 1'b0, 1'b0, 1'b1);
        cyc("ztie", 1'b1, 3'd2, 32'h5555, 1'b1, 3'd6, 32'h6666, 1'b0, 1'b1, 1'b0);

        // clr_req blocks the pending req0, then the sweep restarts at 0.
        cyc("clr", 1'b1, 3'd2, 32'hABCD, 1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        init_sweep("reinit", WORDS);
        cyc("post", 1'b1, 3'd2, 32'hABCD, 1'b0, 3'd0, 32'd0, 1'b0, 1'b1, 1'b0);

        // Async reset in the middle of a sweep (idx=4), then a full sweep again.
        cyc("clr2", 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        init_sweep("part", 4);
        rst_n = 1'b0;
        #1;
        reset_vals("midrst");
        @(negedge clk);
        reset_vals("rsthold");
        rst_n = 1'b1;
        m_ind = '0;
        m_data = '0;
        init_sweep("rsweep", WORDS);

        if (sb.size() != 0) begin
            total++;
            bad++;
            $error("FAIL sb_leftover: got %0d expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
